basis_tableau_buffer: RTL and testbench
=======================================

Name: basis_tableau_buffer

Overview:
- Downstream consumer of the basis-state literal generator. Captures `num_qubit` consecutive stabilizer rows (per-qubit Pauli literals plus a sign) into an internal tableau.
- Once the tableau is complete, streams the rows out one at a time under a valid/ready handshake to the gate-application stage.
- Decouples the free-running generator from the back-pressured datapath.

Parameters:
- num_qubit, 3, qubit count; equals tableau rows and literals per row (≥2)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse; arms capture of a new tableau
- in_valid  input  1  in_literals/in_phase hold a generator row this cycle
- in_literals  input  [1:0] x num_qubit  row literals (00=I, 01=Z, 10=X, 11=Y), index 0 = qubit 0
- in_phase  input  1  row sign (0 = +, 1 = −)
- out_valid  output  1  out_literals/out_phase hold a tableau row
- out_ready  input  1  consumer accepts the row when out_valid&&out_ready
- out_literals  output  [1:0] x num_qubit  current output row
- out_phase  output  1  current output sign
- out_row  output  $clog2(num_qubit)  index of current output row
- busy  output  1  high in LOAD or STREAM
- done  output  1  one-cycle pulse after the last row handshake
- overflow  output  1  sticky; in_valid seen outside LOAD

Behaviour:
- Reset (asynchronous):
  - state=IDLE; wr_ptr=0, rd_ptr=0.
  - Storage cleared: all literals 00, all phases 0.
  - Outputs: out_valid=0, out_literals all 00, out_phase=0, out_row=0, busy=0, done=0, overflow=0.
- IDLE:
  - start=1 → LOAD next cycle; wr_ptr=0; overflow cleared.
  - in_valid in IDLE sets overflow; the row is not stored.
- LOAD:
  - Each in_valid cycle writes row[wr_ptr]←{in_literals,in_phase}, then wr_ptr++.
  - Gaps (in_valid=0) are allowed; no timeout.
  - On the write with wr_ptr==num_qubit−1 → STREAM next cycle, rd_ptr=0.
  - A start pulse in LOAD is ignored.
- STREAM:
  - out_valid=1; out_literals/out_phase/out_row are driven registered-free from row[rd_ptr].
  - Handshake rules: outputs stay stable while out_valid&&!out_ready. A handshake advances rd_ptr next cycle.
  - Handshake at rd_ptr==num_qubit−1 → IDLE next cycle, done=1 for exactly that cycle, out_valid=0.
  - in_valid in STREAM sets overflow and is dropped. start is ignored.
- Latency:
  - First out_valid is 1 cycle after the final LOAD write.
  - Back-to-back rows: one per cycle when out_ready is held high.
- Simultaneous events:
  - done and a start pulse in the same cycle: the start is accepted, since state is IDLE by then.
  - Sticky overflow holds until the next accepted start or reset.
- Reset mid-LOAD or mid-STREAM aborts immediately; partial tableau is discarded.
- Pointers wrap never occurs; the state change precedes any wrap.

Optional Feature:
- Macro: TABLEAU_CHECK_EN.
- When defined:
  - Each row written in LOAD is checked to contain exactly one non-I literal.
  - Violation sets extra output port row_err (1 bit, sticky, cleared on accepted start or reset).
  - The row is still stored.
- When undefined: port row_err is absent and no check logic is built.

Decomposition:
- Shared package qcm_pkg holds:
  - literal typedef (2-bit enum LIT_I, LIT_Z, LIT_X, LIT_Y)
  - row struct {literals, phase}
  - state enum {IDLE, LOAD, STREAM}
- Natural sub-module: tableau_row_mem, a num_qubit-deep row register file with one write port, one async read port, and async clear.
- The FSM and pointers stay in basis_tableau_buffer.

Test Plan:
- num_qubit=3, rows {Z,I,I},{I,Z,I},{I,I,Z} phase 0 on consecutive cycles, out_ready=1:
  - out rows appear in the same order, rows 0..2, on 3 consecutive cycles starting 1 cycle after the 3rd write.
  - done pulses once; busy drops with it.
- Same load, then out_ready toggled 0,1,0,0,1,1:
  - each row is held stable while stalled.
  - out_row sequence is 0,0,1,1,1,2; done follows the final handshake.
- in_valid pulsed in IDLE, and again during STREAM:
  - overflow=1 and stays 1.
  - stored rows are unchanged.
  - next start clears overflow.
- rst asserted after 2 of 3 rows written:
  - all outputs return to reset values immediately.
  - a subsequent start + 3 rows streams only the new rows.
- start and done coincide, with a new 3-row load following: second tableau loads and streams correctly with no lost row.
- With TABLEAU_CHECK_EN, row {Z,X,I} loaded: row_err=1 after the write; row is still streamed as {Z,X,I}.

Source files
------------

// File: rtl/qcm_pkg.sv
// Shared types for the basis-state tableau path: Pauli literal encoding,
// tableau row payload, buffer FSM states and a row-shape helper.
// The row payload is sized by num_qubit_cfg; modules using row_t must be
// built with num_qubit equal to num_qubit_cfg.
package qcm_pkg;

  localparam int unsigned num_qubit_cfg = 3;

  typedef enum logic [1:0] {
    LIT_I = 2'b00,
    LIT_Z = 2'b01,
    LIT_X = 2'b10,
    LIT_Y = 2'b11
  } lit_t;

  typedef logic [num_qubit_cfg-1:0][1:0] lits_t;

  typedef struct packed {
    lits_t literals;
    logic  phase;
  } row_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    STREAM = 2'b10
  } state_t;

  // True when exactly one literal in the row is non-identity.
  function automatic logic single_non_i(input lits_t lits);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < num_qubit_cfg; i++) begin
      if (lits[i] != LIT_I) cnt++;
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/tableau_row_mem.sv
// Row register file for the tableau: one synchronous write port, one
// asynchronous read port, whole array cleared by asynchronous reset.
// Ports: clk, rst (async, active-high), wr_en/wr_addr/wr_data,
//        rd_addr/rd_data (combinational read).
module tableau_row_mem
  import qcm_pkg::*;
#(
  parameter int unsigned depth  = num_qubit_cfg,
  parameter int unsigned addr_w = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [addr_w-1:0] wr_addr,
  input  row_t              wr_data,
  input  logic [addr_w-1:0] rd_addr,
  output row_t              rd_data
);

  row_t rows [depth];

  // Storage: cleared on reset, single write per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < depth; i++) begin
        rows[i] <= '0;
      end
    end else if (wr_en) begin
      rows[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rows[rd_addr];

endmodule

// File: rtl/basis_tableau_buffer.sv
// Captures num_qubit consecutive stabilizer rows from the literal generator
// into a tableau, then streams them out in order under valid/ready.
// Ports:
//   clk, rst (async, active-high)
//   start               one-cycle pulse arming a new capture (accepted in IDLE)
//   in_valid/in_literals/in_phase   generator row input
//   out_valid/out_ready handshake; out_literals/out_phase/out_row current row
//   busy                high while loading or streaming
//   done                one-cycle pulse after the last row handshake
//   overflow            sticky: input row arrived outside capture
//   row_err             (only with TABLEAU_CHECK_EN) sticky: a captured row
//                       did not have exactly one non-identity literal
// Optional feature macro: TABLEAU_CHECK_EN.
module basis_tableau_buffer
  import qcm_pkg::*;
#(
  parameter int unsigned num_qubit = num_qubit_cfg
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic                                              in_valid,
  input  logic [num_qubit-1:0][1:0]                         in_literals,
  input  logic                                              in_phase,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [num_qubit-1:0][1:0]                         out_literals,
  output logic                                              out_phase,
  output logic [((num_qubit > 1) ? $clog2(num_qubit) : 1)-1:0] out_row,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              overflow
`ifdef TABLEAU_CHECK_EN
  ,
  output logic                                              row_err
`endif
);

  localparam int unsigned ptr_w = (num_qubit > 1) ? $clog2(num_qubit) : 1;
  localparam logic [ptr_w-1:0] last_row = ptr_w'(num_qubit - 1);

  state_t           state_q, state_d;
  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic             done_d;
  logic             overflow_d;
  logic             wr_en;
  row_t             wr_row;
  row_t             rd_row;
`ifdef TABLEAU_CHECK_EN
  logic             row_err_d;
`endif

  assign wr_row = {in_literals, in_phase};

  tableau_row_mem #(
    .depth  (num_qubit),
    .addr_w (ptr_w)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_row),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_row)
  );

  // Next-state, pointer and flag logic.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    done_d     = 1'b0;
    overflow_d = overflow;
    wr_en      = 1'b0;
`ifdef TABLEAU_CHECK_EN
    row_err_d  = row_err;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          overflow_d = 1'b0;
`ifdef TABLEAU_CHECK_EN
          row_err_d  = 1'b0;
`endif
        end
        // A dropped row is flagged even if start arrives with it.
        if (in_valid) overflow_d = 1'b1;
      end
      LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
`ifdef TABLEAU_CHECK_EN
          if (!single_non_i(in_literals)) row_err_d = 1'b1;
`endif
          // Leave LOAD instead of incrementing so the pointer never wraps.
          if (wr_ptr_q == last_row) begin
            state_d  = STREAM;
            rd_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + ptr_w'(1);
          end
        end
      end
      STREAM: begin
        if (in_valid) overflow_d = 1'b1;
        if (out_ready) begin
          if (rd_ptr_q == last_row) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + ptr_w'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointers and registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
`ifdef TABLEAU_CHECK_EN
      row_err  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      done     <= done_d;
      overflow <= overflow_d;
`ifdef TABLEAU_CHECK_EN
      row_err  <= row_err_d;
`endif
    end
  end

  // Output row comes straight from storage; zeroed when not streaming.
  assign out_valid    = (state_q == STREAM);
  assign busy         = (state_q != IDLE);
  assign out_literals = out_valid ? rd_row.literals : '0;
  assign out_phase    = out_valid ? rd_row.phase : 1'b0;
  assign out_row      = out_valid ? rd_ptr_q : '0;

endmodule

// File: tb/tb_basis_tableau_buffer.sv
// Scoreboard bench for basis_tableau_buffer (num_qubit = 3): the driver
// keeps a transaction-level model (capture count, expected row queue,
// sticky flags); a negedge monitor checks every output against it.
module tb_basis_tableau_buffer;

  localparam int unsigned NQ = 3;
  localparam logic [1:0] L_I = 2'b00;
  localparam logic [1:0] L_Z = 2'b01;
  localparam logic [1:0] L_X = 2'b10;
  localparam logic [1:0] L_Y = 2'b11;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 in_valid;
  logic [NQ-1:0][1:0]   in_literals;
  logic                 in_phase;
  logic                 out_valid;
  logic                 out_ready;
  logic [NQ-1:0][1:0]   out_literals;
  logic                 out_phase;
  logic [1:0]           out_row;
  logic                 busy;
  logic                 done;
  logic                 overflow;
`ifdef TABLEAU_CHECK_EN
  logic                 row_err;
`endif

  basis_tableau_buffer #(.num_qubit(NQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_literals  (in_literals),
    .in_phase     (in_phase),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_literals (out_literals),
    .out_phase    (out_phase),
    .out_row      (out_row),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
`ifdef TABLEAU_CHECK_EN
    ,
    .row_err      (row_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NQ-1:0][1:0] lits;
    logic               ph;
    int                 idx;
  } exp_t;

  exp_t q[$];
  bit   loading;
  int   cnt;
  bit   exp_ovf;
  bit   exp_err;
  bit   last_hs;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [NQ-1:0][1:0] mk(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] c);
    mk = {c, b, a};
  endfunction

  function automatic int non_i_count(input logic [NQ-1:0][1:0] l);
    int n;
    n = 0;
    for (int i = 0; i < int'(NQ); i++) if (l[i] != 2'b00) n++;
    return n;
  endfunction

  // One clock of stimulus; model is advanced by what the DUT sampled.
  task automatic step(input logic st, input logic iv, input logic [NQ-1:0][1:0] lits,
                      input logic ph, input logic rdy);
    bit   idle_pre, load_pre;
    exp_t e;
    idle_pre    = !loading && (q.size() == 0);
    load_pre    = loading;
    start       = st;
    in_valid    = iv;
    in_literals = lits;
    in_phase    = ph;
    out_ready   = rdy;
    @(posedge clk);
    if (iv) begin
      if (load_pre) begin
        e.lits = lits; e.ph = ph; e.idx = cnt;
        q.push_back(e);
        if (non_i_count(lits) != 1) exp_err = 1'b1;
        cnt++;
        if (cnt == int'(NQ)) loading = 1'b0;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    if (st && idle_pre) begin
      loading = 1'b1; cnt = 0; exp_ovf = 1'b0; exp_err = 1'b0;
    end
    #1;
  endtask

  task automatic idle_steps(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, rdy);
  endtask

  task automatic load3(input logic [NQ-1:0][1:0] a, input logic [NQ-1:0][1:0] b,
                       input logic [NQ-1:0][1:0] c, input logic rdy);
    step(1'b1, 1'b0, '0, 1'b0, rdy);
    step(1'b0, 1'b1, a, 1'b0, rdy);
    step(1'b0, 1'b1, b, 1'b1, rdy);
    step(1'b0, 1'b1, c, 1'b0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_literals", 32'(out_literals), 0);
    chk("rst_out_phase", 32'(out_phase), 0);
    chk("rst_out_row", 32'(out_row), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overflow", 32'(overflow), 0);
`ifdef TABLEAU_CHECK_EN
    chk("rst_row_err", 32'(row_err), 0);
`endif
    q.delete();
    loading = 1'b0; cnt = 0; exp_ovf = 1'b0; exp_err = 1'b0; last_hs = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares every cycle; pops the expected row on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      bit ev;
      ev = !loading && (q.size() > 0);
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(loading || (q.size() > 0)));
      chk("done", 32'(done), 32'(last_hs));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
`ifdef TABLEAU_CHECK_EN
      chk("row_err", 32'(row_err), 32'(exp_err));
`endif
      last_hs = 1'b0;
      if (ev && out_valid) begin
        chk("out_literals", 32'(out_literals), 32'(q[0].lits));
        chk("out_phase", 32'(out_phase), 32'(q[0].ph));
        chk("out_row", 32'(out_row), 32'(q[0].idx));
        if (out_ready) begin
          last_hs = (q[0].idx == int'(NQ) - 1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [NQ-1:0][1:0] r0, r1, r2, rz;
    bit st, iv;
    int guard;
    start = 0; in_valid = 0; in_literals = '0; in_phase = 0; out_ready = 0;
    r0 = mk(L_Z, L_I, L_I);
    r1 = mk(L_I, L_Z, L_I);
    r2 = mk(L_I, L_I, L_Z);
    rz = mk(L_Z, L_X, L_I);
    rst = 1'b0;
    #2;
    do_reset();

    // Basic load and stream with ready held high.
    load3(r0, r1, r2, 1'b1);
    idle_steps(5, 1'b1);

    // Back-pressure pattern 0,1,0,0,1,1.
    load3(r0, r1, r2, 1'b0);
    step(0, 0, '0, 0, 0); step(0, 0, '0, 0, 1); step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0); step(0, 0, '0, 0, 1); step(0, 0, '0, 0, 1);
    idle_steps(2, 1'b1);

    // Overflow in IDLE and during STREAM; next start clears it.
    step(1'b0, 1'b1, mk(L_Y, L_Y, L_Y), 1'b1, 1'b0);
    idle_steps(1, 1'b0);
    load3(r2, r1, r0, 1'b0);
    step(1'b0, 1'b1, mk(L_X, L_X, L_X), 1'b1, 1'b0);
    idle_steps(4, 1'b1);
    load3(r0, r1, r2, 1'b1);
    idle_steps(4, 1'b1);

    // Reset after two of three rows, then a fresh tableau.
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, mk(L_Y, L_I, L_I), 1'b1, 1'b1);
    step(1'b0, 1'b1, mk(L_I, L_Y, L_I), 1'b1, 1'b1);
    do_reset();
    load3(r1, r2, r0, 1'b1);
    idle_steps(3, 1'b1);

    // Start coincides with done; second tableau follows immediately.
    load3(r0, r1, r2, 1'b1);
    idle_steps(3, 1'b1);
    load3(r2, r0, rz, 1'b1);
    idle_steps(5, 1'b1);

    // Malformed row is still stored and streamed.
    load3(rz, r1, r2, 1'b1);
    idle_steps(5, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(0, 7) == 0);
      iv = !st && ($urandom_range(0, 2) != 0);
      step(st, iv, NQ * 2'($urandom), 1'($urandom), 1'($urandom));
    end

    // Drain whatever is in flight, bounded.
    guard = 0;
    while ((loading || q.size() > 0) && guard < 100) begin
      step(1'b0, loading, NQ * 2'($urandom), 1'($urandom), 1'b1);
      guard++;
    end
    n_cmp++;
    if (loading || q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d rows still pending", q.size());
    end
    idle_steps(3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
